cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle sequencer for the single-issue core. It steps each instruction through fetch, decode, execute, optional data-memory access and write-back. It owns the program counter and the overflow flag that feeds the branch decode. It drives the strobes that load the instruction register, write the register file and access data memory. It sits between the combinational opcode decoder, whose outputs it consumes, and the instruction ROM, register file and data memory, which it sequences. It implements the top-level start/done handshake.

## Interface
- PC_W, 10 — program counter width; instruction ROM depth is 2^PC_W.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin execution at PC 0; sampled only in IDLE or HALTED.
- dec_read_mem  input  1  decoded load (valid in DECODE and later).
- dec_write_mem  input  1  decoded store.
- dec_reg_write  input  1  decoded register-file write.
- dec_taken  input  1  decoded branch taken (already qualified by ov_flag).
- dec_halt  input  1  decoded halt.
- ov_we  input  1  the ALU instruction updates the overflow flag.
- ov_in  input  1  ALU overflow result.
- branch_target  input  PC_W  absolute target from the branch LUT.
- mem_ready  input  1  data memory has completed the current access.
- pc  output  PC_W  current instruction address.
- ir_load  output  1  latch the instruction register this cycle.
- reg_we  output  1  register-file write strobe.
- mem_re  output  1  data-memory read strobe.
- mem_we  output  1  data-memory write strobe.
- ov_flag  output  1  registered overflow flag; feeds the decoder's overflow input.
- done  output  1  program halted.
- cycle_cnt  output  32  cycle count (see Configuration).

## Operation
- States:
  - IDLE → FETCH on start.
  - FETCH → DECODE.
  - DECODE → EXEC.
  - EXEC → MEM if dec_read_mem or dec_write_mem; otherwise → WB.
  - MEM → WB on mem_ready; otherwise stay in MEM.
  - WB → HALTED if dec_halt; otherwise → FETCH.
  - HALTED → FETCH on start.
- start out of IDLE or HALTED: pc←0, ov_flag←0, done←0.
- start in any other state is ignored.
- FETCH: ir_load=1.
- EXEC: if ov_we, ov_flag←ov_in at the end of the cycle.
- MEM: mem_re=dec_read_mem and mem_we=dec_write_mem, held until mem_ready is seen.
- A load and store decoded together: mem_re only, and the store is dropped.
- WB: reg_we=dec_reg_write and not dec_halt.
- WB PC update: pc←branch_target if dec_taken, else pc+1, wrapping from 2^PC_W−1 to 0.
- dec_halt and dec_taken together in WB: halt wins, pc unchanged, reg_we=0.
- HALTED: done=1, held until start. All strobes are 0 in IDLE and HALTED.

## Timing
- Reset values: state=IDLE, pc=0, ov_flag=0, done=0, cycle_cnt=0, all strobes 0.
- Strobes are Moore outputs, decoded from registered state only.
- Non-memory instruction: 4 cycles.
- Memory instruction: 5 + N cycles, where N is the number of MEM cycles with mem_ready low.
- mem_ready high on the first MEM cycle gives exactly 1 MEM cycle.
- Branch: the new pc is visible on the FETCH cycle immediately after WB. There is no delay slot.
- done rises on the cycle after the halting WB.
- Reset asserted mid-instruction: immediate return to reset values. No partial write completes after reset asserts.
- mem_ready outside MEM is ignored.

## Configuration
- CPU_SEQ_CYCLE_CNT_EN defined:
  - cycle_cnt clears on an accepted start.
  - It increments every cycle the state is not IDLE or HALTED.
  - It saturates at 2^32−1 and freezes while done=1.
- Undefined: cycle_cnt is tied to 0 and no counter logic is synthesised.

## Structure
- Shared package cpu_pkg holds:
  - the seq_state_t enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED);
  - the opcode and function-code constants used by the decoder;
  - the default PC_W.
- Sub-module pc_unit: PC register with load-zero, increment and load-target controls.
- The FSM, ov_flag and the optional counter stay in cpu_sequencer.

## Test plan
- Reset mid-EXEC with pc=5: state→IDLE, pc=0, strobes 0 while rst_n=0.
- start, then an ADD stream: ir_load is high every 4th cycle; pc goes 0,1,2…; reg_we is high one cycle per instruction.
- Load with mem_ready delayed 3 cycles: mem_re is high for 4 cycles; the instruction takes 8 cycles; reg_we fires once.
- ov_we=1 and ov_in=1, then a taken branch with branch_target=0x3F0: ov_flag=1; pc=0x3F0 on the next FETCH. Separately, pc=0x3FF non-branch wraps to 0.
- dec_halt with dec_taken at pc=7: done=1 the next cycle; pc stays 7; reg_we=0. start then restarts at pc=0 with done=0.
- Macro defined, 3 ADDs then halt: cycle_cnt=16, stable while done=1. Macro undefined: cycle_cnt=0 throughout.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the single-issue core.
//   seq_state_t  - sequencer state encoding (IDLE..HALTED)
//   OP_* / FN_*  - opcode and function-code constants used by the decoder
//   PC_W_DEF     - default program counter width
package cpu_pkg;

  localparam int PC_W_DEF = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALTED = 3'd6
  } seq_state_t;

  // Opcode field values
  localparam logic [3:0] OP_ALU    = 4'h0;
  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_STORE  = 4'h2;
  localparam logic [3:0] OP_BRANCH = 4'h3;
  localparam logic [3:0] OP_HALT   = 4'hF;

  // ALU function-code values
  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_OR  = 3'd3;
  localparam logic [2:0] FN_XOR = 3'd4;

endpackage

// File: rtl/pc_unit.sv
// pc_unit: program counter register.
//   clk, rst_n   - clock, asynchronous active-low reset
//   load_zero    - restart: pc <- 0 (highest priority)
//   load_target  - branch: pc <- target
//   inc          - sequential: pc <- pc + 1, wrapping at 2^PC_W
//   target       - absolute branch target
//   pc           - current instruction address
module pc_unit #(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_zero,
  input  logic            load_target,
  input  logic            inc,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else if (load_zero) begin
      pc_q <= '0;
    end else if (load_target) begin
      pc_q <= target;
    end else if (inc) begin
      // Natural modulo-2^PC_W wrap from all-ones back to zero
      pc_q <= pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/[MEM]/WB sequencer.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - begin at pc 0; honoured only in IDLE or HALTED
//   dec_*               - decoder outputs for the current instruction
//   ov_we, ov_in        - overflow flag update from the ALU (EXEC only)
//   branch_target       - absolute branch target
//   mem_ready           - data memory access complete (looked at in MEM only)
//   pc                  - current instruction address
//   ir_load, reg_we,
//   mem_re, mem_we      - strobes, decoded from the registered state
//   ov_flag             - registered overflow flag
//   done                - high while HALTED
//   cycle_cnt           - busy-cycle counter
//   state_dbg           - current sequencer state
// Build option: CPU_SEQ_CYCLE_CNT_EN enables the cycle counter; when
// undefined cycle_cnt is constant 0.
//
// Handshake: start is a level sampled on the rising edge while the
// sequencer is IDLE or HALTED; done stays high from the cycle after the
// halting write-back until the next accepted start. mem_re/mem_we are held
// in MEM until a rising edge sees mem_ready high.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dec_read_mem,
  input  logic            dec_write_mem,
  input  logic            dec_reg_write,
  input  logic            dec_taken,
  input  logic            dec_halt,
  input  logic            ov_we,
  input  logic            ov_in,
  input  logic [PC_W-1:0] branch_target,
  input  logic            mem_ready,
  output logic [PC_W-1:0] pc,
  output logic            ir_load,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic            ov_flag,
  output logic            done,
  output logic [31:0]     cycle_cnt,
  output seq_state_t      state_dbg
);

  seq_state_t state, state_nxt;
  logic       start_acc;
  logic       pc_zero, pc_inc, pc_tgt;

  assign start_acc = start && (state == IDLE || state == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    reg_we    = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    pc_zero   = 1'b0;
    pc_inc    = 1'b0;
    pc_tgt    = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nxt = FETCH;
          pc_zero   = 1'b1;
        end
      end
      FETCH: begin
        ir_load   = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        state_nxt = (dec_read_mem || dec_write_mem) ? MEM : WB;
      end
      MEM: begin
        // A combined load/store is treated as a load; the store is dropped
        mem_re = dec_read_mem;
        mem_we = dec_write_mem && !dec_read_mem;
        if (mem_ready) state_nxt = WB;
      end
      WB: begin
        // Halt dominates: no register write, pc frozen
        reg_we = dec_reg_write && !dec_halt;
        if (dec_halt) begin
          state_nxt = HALTED;
        end else begin
          state_nxt = FETCH;
          pc_tgt    = dec_taken;
          pc_inc    = !dec_taken;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  pc_unit #(.PC_W(PC_W)) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_zero   (pc_zero),
    .load_target (pc_tgt),
    .inc         (pc_inc),
    .target      (branch_target),
    .pc          (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       ov_flag <= 1'b0;
    else if (start_acc)               ov_flag <= 1'b0;
    else if (state == EXEC && ov_we)  ov_flag <= ov_in;
  end

  assign done      = (state == HALTED);
  assign state_dbg = state;

`ifdef CPU_SEQ_CYCLE_CNT_EN
  logic [31:0] cnt_q;

  // Counts busy cycles only, so it is naturally frozen in IDLE/HALTED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start_acc) begin
      cnt_q <= '0;
    end else if (state != IDLE && state != HALTED && cnt_q != 32'hFFFF_FFFF) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule
